// File: rtl/timer_share_ctrl.sv
// Round-robin sharer of one wishbone timer among NREQ delay requesters.
// Programs compare/load/control, waits for irq or cancel, then clears.
module timer_share_ctrl #(
  parameter int NREQ      = 4,
  parameter int CNTw      = 32,
  parameter int Dw        = 32,
  parameter int Aw        = 3,
  parameter int SELw      = 4,
  parameter int PRESC_SEL = 0,
  parameter int ISR_BIT   = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*CNTw-1:0]      req_period,
  output logic [NREQ-1:0]           done,
  output logic [NREQ-1:0]           cancelled,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic [Dw-1:0]             m_dat_o,
  output logic [SELw-1:0]           m_sel_o,
  output logic [Aw-1:0]             m_addr_o,
  output logic                      m_stb_o,
  output logic                      m_cyc_o,
  output logic                      m_we_o,
  input  logic [Dw-1:0]             m_dat_i,
  input  logic                      m_ack_i,
  input  logic                      irq
);

  localparam int OW = $clog2(NREQ);

  localparam logic [Dw-1:0] CSR_RUN =
    Dw'(7) | (Dw'(PRESC_SEL & 7) << 3);
  localparam logic [Dw-1:0] CSR_CLR = Dw'(1) << ISR_BIT;

  typedef enum logic [2:0] {
    IDLE,
    W_CMP,
    W_TLR,
    W_CSR,
    WAIT_IRQ,
    W_CLR,
    FIN
  } state_t;

  state_t          state;
  state_t          w_next;
  logic [OW-1:0]   ptr;
  logic [OW-1:0]   gnt;
  logic [OW-1:0]   cand;
  logic            any;
  int              j;
  logic [CNTw-1:0] per;
  logic [Dw-1:0]   cmp_val;
  logic            expired;
  logic            stb;
  logic [Aw-1:0]   w_addr;
  logic [Dw-1:0]   w_data;
  logic            unused_dat;

  assign unused_dat = ^m_dat_i;

  assign m_stb_o = stb;
  assign m_cyc_o = stb;
  assign m_we_o  = stb;
  assign m_sel_o = '1;
  assign busy    = (state != IDLE);

  // Pick the first requesting index at or after the pointer, wrapping.
  always_comb begin
    any  = 1'b0;
    gnt  = '0;
    cand = '0;
    j    = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      cand = OW'(j);
      if (!any && req[cand]) begin
        any = 1'b1;
        gnt = cand;
      end
    end
  end

  assign per = req_period[int'(gnt)*CNTw +: CNTw];

  // Address, data and successor for the write owned by each bus state.
  always_comb begin
    w_addr = '0;
    w_data = '0;
    w_next = IDLE;
    unique case (state)
      W_CMP: begin
        w_addr = Aw'(2);
        w_data = cmp_val;
        w_next = W_TLR;
      end
      W_TLR: begin
        w_addr = Aw'(1);
        w_next = W_CSR;
      end
      W_CSR: begin
        w_data = CSR_RUN;
        w_next = WAIT_IRQ;
      end
      W_CLR: begin
        w_data = CSR_CLR;
        w_next = FIN;
      end
      default: ;
    endcase
  end

  // Sequencer: grant, three programming writes, wait, clear, report.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      stb       <= 1'b0;
      m_addr_o  <= '0;
      m_dat_o   <= '0;
      done      <= '0;
      cancelled <= '0;
      owner     <= '0;
      ptr       <= '0;
      cmp_val   <= '0;
      expired   <= 1'b0;
    end else begin
      done      <= '0;
      cancelled <= '0;
      unique case (state)
        IDLE: begin
          if (any) begin
            owner   <= gnt;
            cmp_val <= Dw'((per == '0) ? '0 : per - 1'b1);
            ptr     <= (int'(gnt) == NREQ-1) ? '0 : gnt + 1'b1;
            state   <= W_CMP;
          end
        end
        W_CMP, W_TLR, W_CSR, W_CLR: begin
          if (!stb) begin
            stb      <= 1'b1;
            m_addr_o <= w_addr;
            m_dat_o  <= w_data;
          end else if (m_ack_i) begin
            stb   <= 1'b0;
            state <= w_next;
            if (state == W_CLR) begin
              done[owner]      <= expired;
              cancelled[owner] <= !expired;
            end
          end
        end
        WAIT_IRQ: begin
          if (irq) begin
            expired <= 1'b1;
            state   <= W_CLR;
          end else if (!req[owner]) begin
            expired <= 1'b0;
            state   <= W_CLR;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
